// File: rtl/word_receiver_if.sv
// word_receiver_if: serial-bit input and valid/ready word output bundle for word_receiver
// Signals: clear, enable, in, out_ready (toward receiver); out_data, out_valid, bit_count,
//          overrun and, with WORD_RECEIVER_PARITY_EN defined, parity_err (from receiver).
// Modports: master = bit source / word consumer, slave = the receiver.
interface word_receiver_if #(
    parameter int WIDTH = 8
) ();
    localparam int CW = $clog2(WIDTH + 2);
    logic             clear;
    logic             enable;
    logic             in;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [CW-1:0]    bit_count;
    logic             overrun;
`ifdef WORD_RECEIVER_PARITY_EN
    logic             parity_err;
    modport master (output clear, enable, in, out_ready,
                    input out_data, out_valid, bit_count, overrun, parity_err);
    modport slave (input clear, enable, in, out_ready,
                   output out_data, out_valid, bit_count, overrun, parity_err);
`else
    modport master (output clear, enable, in, out_ready,
                    input out_data, out_valid, bit_count, overrun);
    modport slave (input clear, enable, in, out_ready,
                   output out_data, out_valid, bit_count, overrun);
`endif
endinterface

// File: rtl/word_receiver.sv
// word_receiver: shifts in serial bits on enable strobes and presents completed words with valid/ready
// Ports: clk; rst_n (asynchronous, active-low); bus (word_receiver_if.slave):
//        clear, enable, in, out_ready in; out_data, out_valid, bit_count, overrun out.
// Optional: WORD_RECEIVER_PARITY_EN appends an even-parity bit to each frame and adds parity_err.
module word_receiver #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input logic            clk,
    input logic            rst_n,
    word_receiver_if.slave bus
);
`ifdef WORD_RECEIVER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             done;
    logic             accept;
    assign shifted = (MSB_FIRST != 0) ? {shift_reg[WIDTH-2:0], bus.in} : {bus.in, shift_reg[WIDTH-1:1]};
`ifdef WORD_RECEIVER_PARITY_EN
    // the completing bit is the parity bit, so the data is already fully shifted in
    assign word = shift_reg;
`else
    assign word = shifted;
`endif
    assign done   = bus.enable && !bus.clear && bus.bit_count == CW'(FRAME - 1);
    assign accept = bus.out_valid && bus.out_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg     <= '0;
            bus.bit_count <= '0;
        end else if (bus.clear) begin
            shift_reg     <= '0;
            bus.bit_count <= '0;
        end else if (bus.enable) begin
            shift_reg     <= done ? '0 : shifted;
            bus.bit_count <= done ? '0 : bus.bit_count + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_data   <= '0;
            bus.out_valid  <= 1'b0;
            bus.overrun    <= 1'b0;
`ifdef WORD_RECEIVER_PARITY_EN
            bus.parity_err <= 1'b0;
`endif
        end else begin
            // a completing word loads if the output slot is empty or being drained on this edge
            if (done && (!bus.out_valid || bus.out_ready)) begin
                bus.out_data   <= word;
                bus.out_valid  <= 1'b1;
`ifdef WORD_RECEIVER_PARITY_EN
                bus.parity_err <= ^shift_reg ^ bus.in;
`endif
            end else if (accept) begin
                bus.out_valid <= 1'b0;
            end
            if (bus.clear)
                bus.overrun <= 1'b0;
            else if (done && bus.out_valid && !bus.out_ready)
                bus.overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_word_receiver.sv
// tb_word_receiver: directed stimulus with a bit-queue reference model for MSB-first and LSB-first receivers
module tb_word_receiver;
`ifdef WORD_RECEIVER_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    word_receiver_if #(.WIDTH(8)) bus_a ();
    word_receiver_if #(.WIDTH(8)) bus_b ();
    assign bus_b.clear     = bus_a.clear;
    assign bus_b.enable    = bus_a.enable;
    assign bus_b.in        = bus_a.in;
    assign bus_b.out_ready = bus_a.out_ready;
    word_receiver #(.WIDTH(8), .MSB_FIRST(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    word_receiver #(.WIDTH(8), .MSB_FIRST(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // Reference model: bits collected in arrival order, word built once a frame is complete.
    bit q[$];
    int m_dm = 0, m_dl = 0;
    bit m_valid = 0, m_ovr = 0, m_perr = 0;
    int wm, wl;
    bit pe, done, xfer;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_dm = 0; m_dl = 0; m_valid = 0; m_ovr = 0; m_perr = 0;
        end else begin
            xfer = m_valid && bus_a.out_ready;
            done = 0;
            if (bus_a.clear) begin
                q.delete();
                m_ovr = 0;
            end else if (bus_a.enable) begin
                q.push_back(bus_a.in);
                if (q.size() == FRAME) begin
                    done = 1; wm = 0; wl = 0; pe = 0;
                    for (int i = 0; i < 8; i++) begin
                        wm = wm * 2 + int'(q[i]);
                        wl = wl + int'(q[i]) * (1 << i);
                    end
                    for (int i = 0; i < FRAME; i++) pe ^= q[i];
                    q.delete();
                end
            end
            if (done) begin
                if (!m_valid || xfer) begin
                    m_dm = wm; m_dl = wl; m_valid = 1; m_perr = pe;
                end else m_ovr = 1;
            end else if (xfer) m_valid = 0;
        end
    end
    always @(negedge clk) begin
        chk("data_msb", 32'(bus_a.out_data), m_dm);
        chk("data_lsb", 32'(bus_b.out_data), m_dl);
        chk("valid", 32'(bus_a.out_valid), 32'(m_valid));
        chk("valid_b", 32'(bus_b.out_valid), 32'(m_valid));
        chk("count", 32'(bus_a.bit_count), q.size());
        chk("count_b", 32'(bus_b.bit_count), q.size());
        chk("overrun", 32'(bus_a.overrun), 32'(m_ovr));
`ifdef WORD_RECEIVER_PARITY_EN
        chk("parity_err", 32'(bus_a.parity_err), 32'(m_perr));
`endif
    end
    task automatic send_frame(input logic [7:0] w, input logic p, input logic rdy_last);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            bus_a.enable = 1'b1;
            bus_a.in = w[i];
            if (i == 0 && FRAME == 8) bus_a.out_ready = rdy_last;
        end
`ifdef WORD_RECEIVER_PARITY_EN
        @(negedge clk);
        bus_a.in = p;
        bus_a.out_ready = rdy_last;
`else
        if (p) bus_a.in = bus_a.in;
`endif
    endtask
    task automatic send_word(input logic [7:0] w, input logic rdy_last);
        send_frame(w, ^w, rdy_last);
    endtask
    task automatic idle();
        @(negedge clk);
        bus_a.enable = 1'b0;
        bus_a.in = 1'b0;
    endtask
    task automatic drain();
        @(negedge clk);
        bus_a.out_ready = 1'b1;
        @(negedge clk);
        bus_a.out_ready = 1'b0;
    endtask
    initial begin
        rst_n = 1'b0;
        bus_a.clear = 1'b0; bus_a.enable = 1'b0; bus_a.in = 1'b0; bus_a.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(bus_a.out_data), 0);
        chk("rst_valid", 32'(bus_a.out_valid), 0);
        chk("rst_count", 32'(bus_a.bit_count), 0);
        rst_n = 1'b1;
        // 1,0,1,0,0,1,1,0
        send_word(8'hA6, 1'b0);
        idle();
        chk("lit_a6", 32'(bus_a.out_data), 32'h A6);
        chk("lit_65", 32'(bus_b.out_data), 32'h65);
        chk("lit_a6_valid", 32'(bus_a.out_valid), 1);
        chk("lit_a6_count", 32'(bus_a.bit_count), 0);
        drain();
        chk("lit_drained", 32'(bus_a.out_valid), 0);
        // overrun while stalled
        send_word(8'h11, 1'b0);
        idle();
        send_word(8'h22, 1'b0);
        idle();
        chk("lit_ovr_data", 32'(bus_a.out_data), 32'h11);
        chk("lit_ovr_lsb", 32'(bus_b.out_data), 32'h88);
        chk("lit_ovr_set", 32'(bus_a.overrun), 1);
        drain();
        chk("lit_ovr_valid", 32'(bus_a.out_valid), 0);
        chk("lit_ovr_sticky", 32'(bus_a.overrun), 1);
        @(negedge clk);
        bus_a.clear = 1'b1;
        @(negedge clk);
        bus_a.clear = 1'b0;
        chk("lit_ovr_clr", 32'(bus_a.overrun), 0);
        // completion coinciding with transfer
        send_word(8'h3C, 1'b0);
        send_word(8'hC3, 1'b1);
        chk("lit_3c", 32'(bus_a.out_data), 32'h3C);
        idle();
        bus_a.out_ready = 1'b0;
        chk("lit_c3", 32'(bus_a.out_data), 32'hC3);
        chk("lit_c3_valid", 32'(bus_a.out_valid), 1);
        chk("lit_c3_ovr", 32'(bus_a.overrun), 0);
        drain();
        // clear with simultaneous enable mid-word
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_a.enable = 1'b1;
            bus_a.in = 1'b1;
        end
        @(negedge clk);
        bus_a.clear = 1'b1;
        @(negedge clk);
        bus_a.clear = 1'b0;
        bus_a.enable = 1'b0;
        chk("lit_clr_count", 32'(bus_a.bit_count), 0);
        chk("lit_clr_noword", 32'(bus_a.out_valid), 0);
        send_word(8'h81, 1'b0);
        idle();
        chk("lit_81", 32'(bus_a.out_data), 32'h81);
        // asynchronous reset mid-word with a held word
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_a.enable = 1'b1;
            bus_a.in = i[0];
        end
        @(negedge clk);
        bus_a.enable = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("lit_arst_data", 32'(bus_a.out_data), 0);
        chk("lit_arst_valid", 32'(bus_a.out_valid), 0);
        chk("lit_arst_count", 32'(bus_a.bit_count), 0);
        chk("lit_arst_ovr", 32'(bus_a.overrun), 0);
        #1 rst_n = 1'b1;
        send_word(8'hFF, 1'b0);
        idle();
        chk("lit_ff", 32'(bus_a.out_data), 32'hFF);
        chk("lit_ff_lsb", 32'(bus_b.out_data), 32'hFF);
        drain();
`ifdef WORD_RECEIVER_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        idle();
        chk("lit_par_ok", 32'(bus_a.parity_err), 0);
        drain();
        send_frame(8'h07, 1'b0, 1'b0);
        idle();
        chk("lit_par_bad", 32'(bus_a.parity_err), 1);
        chk("lit_par_data", 32'(bus_a.out_data), 32'h07);
        drain();
`endif
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/word_receiver.md
WORD_RECEIVER -- requirements
Module: word_receiver

Interface
REQ-001 Parameter WIDTH, default 8: data bits per word; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = first received bit lands in out_data[WIDTH-1]; 0 = first received bit lands in out_data[0].
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 clear  input  1  synchronous abort of the partial word.
REQ-006 enable  input  1  bit strobe; in is sampled on each clk edge where enable=1.
REQ-007 in  input  1  serial data bit.
REQ-008 out_data  output  WIDTH  last completed word, registered.
REQ-009 out_valid  output  1  out_data holds an unconsumed word.
REQ-010 out_ready  input  1  consumer accepts out_data when high together with out_valid.
REQ-011 bit_count  output  $clog2(WIDTH+2)  bits received in the current word.
REQ-012 overrun  output  1  sticky: a completed word was dropped.
REQ-013 parity_err  output  1  present only when WORD_RECEIVER_PARITY_EN is defined; see Configuration.

Function
REQ-014 The block SHALL hold a WIDTH-bit shift register and bit counter; each enable edge shifts in one bit per MSB_FIRST and increments bit_count.
REQ-015 The word SHALL complete on the enable edge that receives bit number FRAME (FRAME = WIDTH, or WIDTH+1 with parity); on that same edge bit_count returns to 0.
REQ-016 The completed word SHALL appear on out_data with out_valid=1 in the cycle immediately after the completing edge (latency 1).
REQ-017 out_valid SHALL stay high and out_data stable until a clk edge with out_valid=1 and out_ready=1; out_valid then falls unless a new word completes on the same edge.
REQ-018 Word completion on the same edge as a valid/ready transfer: new word SHALL load, out_valid stays 1, no overrun.
REQ-019 Word completion while out_valid=1 and out_ready=0: new word SHALL be discarded, out_data unchanged, overrun set to 1.
REQ-020 overrun SHALL remain 1 until clear or reset.
REQ-021 clear=1 SHALL zero the shift register, bit_count and overrun on that edge; out_data/out_valid untouched; clear overrides a simultaneous enable.
REQ-022 out_ready with out_valid=0 SHALL have no effect.
REQ-023 Shift register contents SHALL NOT be visible on out_data before completion.

Reset
REQ-024 rst_n=0 SHALL immediately force shift register, bit_count, out_data, out_valid, overrun (and parity_err) to 0 regardless of clk.
REQ-025 Reset mid-word SHALL discard the partial word; the first enable after release counts as bit 1.
REQ-026 Reset release SHALL be synchronised externally; the block requires no extra cycles after rst_n rises.

Configuration
REQ-027 Macro WORD_RECEIVER_PARITY_EN defined: FRAME = WIDTH+1; bit WIDTH+1 is an even-parity bit not stored in out_data; parity_err = (XOR of data bits XOR parity bit), loaded with out_data and valid while out_valid=1; dropped words do not update it.
REQ-028 Macro undefined: FRAME = WIDTH, no parity_err port, no parity logic.

Verification
REQ-029 WIDTH=8, MSB_FIRST=1, enable continuous, bits 1,0,1,0,0,1,1,0 -> cycle after 8th edge out_data=0xA6, out_valid=1, bit_count=0.
REQ-030 MSB_FIRST=0, same bit sequence -> out_data=0x65.
REQ-031 out_ready=0, two words 0x11 then 0x22 -> out_data stays 0x11, overrun=1; then out_ready=1 one cycle -> out_valid=0, overrun still 1; clear -> overrun=0.
REQ-032 out_ready=1 held, back-to-back words 0x3C,0xC3 with final bit of second coinciding with transfer of first -> out_valid never drops, out_data 0x3C then 0xC3, overrun=0.
REQ-033 Four bits received, rst_n pulsed low mid-cycle -> all outputs 0 asynchronously; next 8 bits of 0xFF -> out_data=0xFF (no leftover bits).
REQ-034 PARITY_EN, data 0x07 with parity bit 1 -> parity_err=0; parity bit 0 -> parity_err=1; clear at bit 5 plus simultaneous enable -> bit_count=0, no word produced.
